// File: rtl/lzc_seq_ctrl.sv
// lzc_seq_ctrl: multi-cycle leading-zero counter sequencer.
// Scans a WIDTH-bit operand MSB-first, CHUNK bits per cycle, through one
// shared combinational LZC and stops at the first non-zero chunk.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake, operand on in_a
//   out_valid/out_ready result handshake, result on out_cnt/out_zero
//   busy                high while scanning or holding a result
//   lzc_a               chunk presented to the shared LZC
//   lzc_cnt/lzc_zero    LZC answer for lzc_a (same cycle)

module lzc_seq_ctrl #(
   parameter  int WIDTH  = 64,
   parameter  int CHUNK  = 16,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int CW     = $clog2(CHUNK),
   localparam int RW     = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    out_cnt,
   output logic             out_zero,
   output logic             busy,
   output logic [CHUNK-1:0] lzc_a,
   input  logic [CW-1:0]    lzc_cnt,
   input  logic             lzc_zero
);

   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [IW-1:0] LAST    = IW'(NCHUNK - 1);
   localparam logic [RW-1:0] CHUNK_R = RW'(CHUNK);
   localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [IW-1:0]    idx;
   logic [RW-1:0]    acc;

   // Current chunk always sits in the top bits of sreg; the LZC only
   // sees it while scanning.
   assign lzc_a = (state == SCAN) ? sreg[WIDTH-1 -: CHUNK] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_cnt   <= '0;
         out_zero  <= 1'b0;
         busy      <= 1'b0;
         sreg      <= '0;
         idx       <= '0;
         acc       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg     <= in_a;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (!lzc_zero) begin
                  out_cnt   <= acc + RW'(lzc_cnt);
                  out_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (idx == LAST) begin
                  out_cnt   <= WIDTH_R;
                  out_zero  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  acc  <= acc + CHUNK_R;
                  sreg <= sreg << CHUNK;
                  idx  <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// tb_lzc_seq_ctrl: self-checking bench for lzc_seq_ctrl (64/16).
// Behavioural LZC on lzc_*, scoreboard of reference results.

module tb_lzc_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_cnt;
   logic        out_zero;
   logic        busy;
   logic [15:0] lzc_a;
   logic [3:0]  lzc_cnt;
   logic        lzc_zero;
   logic [3:0]  junk;

   lzc_seq_ctrl #(
      .WIDTH(64),
      .CHUNK(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_cnt  (out_cnt),
      .out_zero (out_zero),
      .busy     (busy),
      .lzc_a    (lzc_a),
      .lzc_cnt  (lzc_cnt),
      .lzc_zero (lzc_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // lzc_cnt is meaningless when the chunk is zero: drive noise there.
   always @(negedge clk) junk = 4'($urandom);

   always_comb begin
      lzc_zero = (lzc_a == 16'h0);
      lzc_cnt  = junk;
      if (!lzc_zero) begin
         lzc_cnt = 4'd0;
         for (int i = 0; i < 16; i++)
            if (lzc_a[i]) lzc_cnt = 4'(15 - i);
      end
   end

   typedef struct packed {
      logic [63:0] a;
      logic [6:0]  cnt;
      logic        zero;
      logic [2:0]  scans;
   } exp_t;

   exp_t        sb[$];
   int          n_pass;
   int          n_total;
   int          scans_seen;
   logic [15:0] seq_log[8];

   function automatic exp_t model(input logic [63:0] a);
      exp_t e;
      int   c;
      bit   seen;
      c    = 0;
      seen = 0;
      for (int i = 63; i >= 0; i--) begin
         if (a[i]) seen = 1;
         if (!seen) c++;
      end
      e.a     = a;
      e.cnt   = 7'(c);
      e.zero  = (a == 64'h0);
      e.scans = (a == 64'h0) ? 3'd4 : 3'(c / 16 + 1);
      return e;
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      e = '0;
      if (sb.size() != 0) e = sb.pop_front();
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [63:0] a);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) begin
         n_total++;
         $display("FAIL send_timeout in_ready=%0b want 1", in_ready);
      end
      in_valid = 1'b1;
      in_a     = a;
      sb.push_back(model(a));
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = {$urandom, $urandom};
   endtask

   // Starts in the first SCAN cycle; stops at the negedge with out_valid.
   task automatic wait_result();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         if (n < 8) seq_log[n] = lzc_a;
         n++;
         @(negedge clk);
      end
      scans_seen = n;
      if (n == 20) begin
         n_total++;
         $display("FAIL result_timeout out_valid=%0b want 1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 64'h0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1)
         $display("FAIL rst_in_ready got %0b want 1", in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b0)
         $display("FAIL rst_out_valid got %0b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (out_cnt !== 7'd0)
         $display("FAIL rst_out_cnt got %0d want 0", out_cnt);
      else n_pass++;
      n_total++;
      if (out_zero !== 1'b0)
         $display("FAIL rst_out_zero got %0b want 0", out_zero);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0)
         $display("FAIL rst_busy got %0b want 0", busy);
      else n_pass++;
      n_total++;
      if (lzc_a !== 16'h0)
         $display("FAIL rst_lzc_a got %h want 0", lzc_a);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_table();
      logic [63:0] ops[$];
      exp_t        e;
      ops = '{64'h8000_0000_0000_0000,
              64'h0000_0000_0001_0000,
              64'h0,
              64'h1,
              64'h0000_7FFF_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF,
              64'h0000_0000_0000_8000};
      for (int r = 0; r < 8; r++)
         ops.push_back({$urandom, $urandom} >> $urandom_range(0, 63));
      out_ready = 1'b1;
      foreach (ops[i]) begin
         send(ops[i]);
         wait_result();
         e = pop_exp();
         n_total++;
         if (scans_seen !== int'(e.scans))
            $display("FAIL scans a=%h got %0d want %0d",
                     e.a, scans_seen, e.scans);
         else n_pass++;
         for (int j = 0; j < int'(e.scans) && j < scans_seen; j++) begin
            n_total++;
            if (seq_log[j] !== e.a[63-16*j -: 16])
               $display("FAIL lzc_a a=%h step %0d got %h want %h",
                        e.a, j, seq_log[j], e.a[63-16*j -: 16]);
            else n_pass++;
         end
         n_total++;
         if (out_cnt !== e.cnt)
            $display("FAIL cnt a=%h got %0d want %0d",
                     e.a, out_cnt, e.cnt);
         else n_pass++;
         n_total++;
         if (out_zero !== e.zero)
            $display("FAIL zero a=%h got %0b want %0b",
                     e.a, out_zero, e.zero);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL after_hs a=%h got rdy=%0b vld=%0b want 1 0",
                     e.a, in_ready, out_valid);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      exp_t        e;
      logic [63:0] b;
      b         = 64'h0000_0000_0000_8000;
      out_ready = 1'b0;
      send(64'h0000_0F00_0000_0000);
      wait_result();
      e = pop_exp();
      n_total++;
      if (out_cnt !== 7'd20 || e.cnt !== 7'd20)
         $display("FAIL bp_cnt got %0d want 20", out_cnt);
      else n_pass++;
      in_valid = 1'b1;
      in_a     = b;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_cnt !== e.cnt || in_ready !== 1'b0)
            $display("FAIL bp_hold cyc %0d got vld=%0b cnt=%0d rdy=%0b want 1 %0d 0",
                     i, out_valid, out_cnt, in_ready, e.cnt);
         else n_pass++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL bp_release got vld=%0b rdy=%0b busy=%0b want 0 1 0",
                  out_valid, in_ready, busy);
      else n_pass++;
      sb.push_back(model(b));
      @(negedge clk);
      in_valid = 1'b0;
      n_total++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL bp_accept got busy=%0b rdy=%0b want 1 0",
                  busy, in_ready);
      else n_pass++;
      wait_result();
      e = pop_exp();
      n_total++;
      if (out_cnt !== e.cnt || scans_seen !== int'(e.scans))
         $display("FAIL bp_next got cnt=%0d scans=%0d want %0d %0d",
                  out_cnt, scans_seen, e.cnt, e.scans);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      out_ready = 1'b1;
      send(64'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          busy !== 1'b0 || lzc_a !== 16'h0)
         $display("FAIL mid_rst got rdy=%0b vld=%0b busy=%0b lzc_a=%h want 1 0 0 0",
                  in_ready, out_valid, busy, lzc_a);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if (out_valid !== 1'b0)
            $display("FAIL mid_rst_quiet cyc %0d got %0b want 0",
                     i, out_valid);
         else n_pass++;
      end
      send(64'h00FF_0000_0000_0000);
      wait_result();
      e = pop_exp();
      n_total++;
      if (out_cnt !== 7'd8 || e.cnt !== 7'd8 || out_zero !== 1'b0)
         $display("FAIL mid_rst_next got cnt=%0d zero=%0b want 8 0",
                  out_cnt, out_zero);
      else n_pass++;
      n_total++;
      if (scans_seen !== 1)
         $display("FAIL mid_rst_scans got %0d want 1", scans_seen);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_table();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lzc_seq_ctrl.md
Name: lzc_seq_ctrl

Overview:
- Multi-cycle sequencer that computes the leading-zero count of a WIDTH-bit operand.
- It time-multiplexes one external combinational CHUNK-bit leading-zero counter.
- Chunks are fed to the counter MSB-first, and the scan terminates early at the first non-zero chunk.
- Sits between a normalisation stage and the shared LZC instance, with valid/ready handshakes on both the operand and result sides.

Parameters:
- WIDTH, 64: operand width; must be an integer multiple of CHUNK.
- CHUNK, 16: width of the shared LZC instance; power of two, at least 2.
- NCHUNK, WIDTH/CHUNK: number of chunks (derived).
- CW, $clog2(CHUNK): width of the LZC count bus (derived).
- RW, $clog2(WIDTH)+1: result width; must be able to hold the value WIDTH (derived).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: controller can accept an operand.
- in_a, input, WIDTH: operand.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_cnt, output, RW: leading-zero count of the operand, range 0..WIDTH.
- out_zero, output, 1: operand was all zeros.
- busy, output, 1: high in SCAN or DONE.
- lzc_a, output, CHUNK: chunk driven to the shared LZC.
- lzc_cnt, input, CW: LZC leading-zero count of lzc_a; meaningful only when lzc_zero=0.
- lzc_zero, input, 1: LZC flag, lzc_a is all zeros.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_cnt=0, out_zero=0, busy=0, lzc_a=0.
  - Chunk index and accumulator clear.
  - Reset mid-SCAN or mid-DONE discards the operation silently; no result is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a into a shift register, clear the accumulator and index, go to SCAN.
- SCAN:
  - in_ready=0.
  - lzc_a = top CHUNK bits of the shift register (chunk idx, MSB-first). lzc_a=0 in every other state.
  - The LZC is combinational; its result is sampled in the same cycle.
  - If lzc_zero=0: out_cnt <= acc + lzc_cnt, out_zero <= 0, go to DONE.
  - If lzc_zero=1 and idx<NCHUNK-1: acc += CHUNK, shift register shifts left by CHUNK, idx++, stay in SCAN.
  - If lzc_zero=1 and idx==NCHUNK-1: out_cnt <= WIDTH, out_zero <= 1, go to DONE.
- DONE:
  - out_valid=1; out_cnt and out_zero are held stable.
  - On out_ready=1: go to IDLE.
  - The next operand is accepted no earlier than the cycle after the result handshake.
- Latency:
  - Let k be the index of the first non-zero chunk, or NCHUNK-1 if the operand is all zeros.
  - SCAN lasts k+1 cycles; out_valid rises on the edge ending the last SCAN cycle.
  - Minimum accept-to-out_valid is 1 cycle of SCAN, then out_valid; maximum is NCHUNK SCAN cycles.
- Outputs out_cnt and out_zero are registered.
- in_a is ignored outside the accept cycle; later changes to in_a do not affect an operation in progress.
- Arithmetic: the accumulator is RW bits wide and never overflows (max WIDTH-CHUNK+CHUNK-1 or WIDTH).
- The result is independent of the value of lzc_cnt whenever lzc_zero=1.
- out_ready held high in IDLE or SCAN has no effect.
- busy = state != IDLE.

Test Plan:
All cases use WIDTH=64, CHUNK=16, with a behavioural LZC model on lzc_*.
- in_a=64'h8000_0000_0000_0000, out_ready=1 -> 1 SCAN cycle; out_valid the next cycle with out_cnt=0, out_zero=0; in_ready high again the cycle after.
- in_a=64'h0000_0000_0001_0000 -> lzc_a sequence 0000, 0000, 0001; 3 SCAN cycles; out_cnt=47, out_zero=0.
- in_a=64'h0 -> 4 SCAN cycles; lzc_a=0 each cycle; out_cnt=64, out_zero=1.
- in_a=64'h1 -> 4 SCAN cycles; out_cnt=63, out_zero=0. in_a=64'h0000_7FFF_0000_0000 -> out_cnt=17 after 2 SCAN cycles.
- Backpressure: result ready with out_ready=0 for 5 cycles while in_valid=1 with a new operand -> out_valid and out_cnt held constant and in_ready=0 throughout; new operand accepted only in the cycle after out_ready=1.
- rst=1 during the 2nd SCAN cycle of in_a=0 -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, lzc_a=0; no result emitted. A following in_a=64'h00FF_0000_0000_0000 -> out_cnt=8.
